// File: rtl/fsm_test.sv
// fsm_test: I2C master sequencer for one VEML6070-class UV measurement.
// Each request runs three frames:
//   - write CMD_BYTE to the command register;
//   - read the MSB data register;
//   - read the LSB data register.
// The result {MSB, LSB} is presented on uv_data.
// Every bus phase is one bit time of four quarter-ticks, CLK_DIV clocks each.
// Optional build macro I2C_ACK_CHECK_EN: sample every slave ACK slot. On a
// NACK, end the transaction with STOP + bus-free and leave uv_data untouched.

module fsm_test #(
  parameter int unsigned CLK_DIV  = 125,
  parameter logic [7:0]  CMD_BYTE = 8'h06
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        ready,
  output logic        i2c_scl,
  inout  wire         i2c_sda,
  output logic [15:0] uv_data
);

  localparam int unsigned     DivW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DivW-1:0] DivMax = DivW'(CLK_DIV - 1);

  // Bus addresses of the three frames (7-bit address + R/W in bit 0)
  localparam logic [7:0] AddrCmdWr = 8'h70;
  localparam logic [7:0] AddrMsbRd = 8'h73;
  localparam logic [7:0] AddrLsbRd = 8'h71;

  typedef enum logic [3:0] {
    StIdle,
    StStart,
    StWriteBit,
    StSlaveAck,
    StReadBit,
    StMasterNack,
    StStop,
    StGap,
    StDone
  } state_e;

  state_e          state_q;
  logic [DivW-1:0] div_q;      // clocks within the current quarter
  logic [1:0]      quarter_q;  // quarter within the current bit time
  logic [2:0]      bit_q;      // bit index within the current byte, 0 = MSB
  logic [1:0]      frame_q;    // 0 = command, 1 = MSB read, 2 = LSB read
  logic            byte_q;     // frame 0 only: 0 = address byte, 1 = command byte
  logic            nack_q;     // transaction aborted by a slave NACK
  logic [7:0]      rx_q;
  logic [7:0]      msb_q;
  logic [7:0]      lsb_q;
  logic            sda_low_q;  // 1 = pull SDA low, 0 = release
`ifdef I2C_ACK_CHECK_EN
  logic            ack_low_q;  // SDA seen low in the current ACK slot
`endif

  logic       tick;
  logic       bit_end;
  logic       sda_in;
  logic [7:0] tx_byte;
  logic       tx_bit;
  logic       scl_nxt;
  logic       sda_low_nxt;

  // Open drain: SDA is only ever pulled low or released
  assign i2c_sda = sda_low_q ? 1'b0 : 1'bz;
  assign sda_in  = i2c_sda;

  assign tick    = (div_q == DivMax);
  assign bit_end = tick && (quarter_q == 2'd3);

  // Byte the master is currently shifting out, and its current bit
  always_comb begin
    tx_byte = AddrLsbRd;
    case (frame_q)
      2'd0:    tx_byte = byte_q ? CMD_BYTE : AddrCmdWr;
      2'd1:    tx_byte = AddrMsbRd;
      default: tx_byte = AddrLsbRd;
    endcase
    tx_bit = tx_byte[3'd7 - bit_q];
  end

  // Bus levels for the current phase and quarter; registered below
  always_comb begin
    scl_nxt     = 1'b1;
    sda_low_nxt = 1'b0;
    unique case (state_q)
      // SCL stays high while SDA falls at mid-bit, then SCL drops
      StStart: begin
        scl_nxt     = (quarter_q != 2'd3);
        sda_low_nxt = quarter_q[1];
      end
      // Data set while SCL low in quarter 0, SCL high in quarters 1-2
      StWriteBit: begin
        scl_nxt     = (quarter_q == 2'd1) || (quarter_q == 2'd2);
        sda_low_nxt = !tx_bit;
      end
      // SDA released: slave drives ACK or data, master NACK is a released bit
      StSlaveAck, StReadBit, StMasterNack: begin
        scl_nxt = (quarter_q == 2'd1) || (quarter_q == 2'd2);
      end
      // SDA held low under a low SCL, SCL rises, then SDA rises
      StStop: begin
        scl_nxt     = (quarter_q != 2'd0);
        sda_low_nxt = !quarter_q[1];
      end
      default: begin
        scl_nxt     = 1'b1;
        sda_low_nxt = 1'b0;
      end
    endcase
  end

  // Sequencer: handshake, quarter timing, frame/byte/bit counting and capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      div_q     <= '0;
      quarter_q <= 2'd0;
      bit_q     <= 3'd0;
      frame_q   <= 2'd0;
      byte_q    <= 1'b0;
      nack_q    <= 1'b0;
      rx_q      <= 8'h00;
      msb_q     <= 8'h00;
      lsb_q     <= 8'h00;
      sda_low_q <= 1'b0;
`ifdef I2C_ACK_CHECK_EN
      ack_low_q <= 1'b0;
`endif
      ready     <= 1'b1;
      i2c_scl   <= 1'b1;
      uv_data   <= 16'h0000;
    end else begin
      i2c_scl   <= scl_nxt;
      sda_low_q <= sda_low_nxt;

      if (state_q == StIdle) begin
        div_q     <= '0;
        quarter_q <= 2'd0;
        if (start) begin
          state_q <= StStart;
          ready   <= 1'b0;
          frame_q <= 2'd0;
          byte_q  <= 1'b0;
          bit_q   <= 3'd0;
          nack_q  <= 1'b0;
        end
      end else if (state_q == StDone) begin
        if (!nack_q) begin
          uv_data <= {msb_q, lsb_q};
        end
        ready   <= 1'b1;
        state_q <= StIdle;
      end else begin
        div_q <= tick ? '0 : div_q + 1'b1;
        if (tick) begin
          quarter_q <= quarter_q + 2'd1;
        end

        // SDA is sampled on the last clock of quarter 1, while SCL is high
        if (tick && (quarter_q == 2'd1)) begin
          if (state_q == StReadBit) begin
            rx_q <= {rx_q[6:0], sda_in};
          end
`ifdef I2C_ACK_CHECK_EN
          if (state_q == StSlaveAck) begin
            ack_low_q <= (sda_in == 1'b0);
          end
`endif
        end

        if (bit_end) begin
          unique case (state_q)
            StStart: begin
              bit_q   <= 3'd0;
              state_q <= StWriteBit;
            end
            StWriteBit: begin
              bit_q <= bit_q + 3'd1;
              if (bit_q == 3'd7) begin
                state_q <= StSlaveAck;
              end
            end
            StSlaveAck: begin
              bit_q <= 3'd0;
`ifdef I2C_ACK_CHECK_EN
              if (!ack_low_q) begin
                nack_q  <= 1'b1;
                state_q <= StStop;
              end else
`endif
              if (frame_q != 2'd0) begin
                state_q <= StReadBit;
              end else if (!byte_q) begin
                byte_q  <= 1'b1;
                state_q <= StWriteBit;
              end else begin
                state_q <= StStop;
              end
            end
            StReadBit: begin
              bit_q <= bit_q + 3'd1;
              if (bit_q == 3'd7) begin
                if (frame_q == 2'd1) begin
                  msb_q <= rx_q;
                end else begin
                  lsb_q <= rx_q;
                end
                state_q <= StMasterNack;
              end
            end
            StMasterNack: begin
              state_q <= StStop;
            end
            StStop: begin
              state_q <= StGap;
            end
            // Bus-free bit time, then next frame or finish
            StGap: begin
              if (nack_q || (frame_q == 2'd2)) begin
                state_q <= StDone;
              end else begin
                frame_q <= frame_q + 2'd1;
                byte_q  <= 1'b0;
                state_q <= StStart;
              end
            end
            default: begin
              state_q <= StIdle;
            end
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_fsm_test.sv
// Bench for fsm_test. A small clock divider keeps the run short.
// An I2C slave/bus monitor records the bytes the master writes, ACKs them and
// serves the MSB/LSB data. A per-cycle model checks ready, uv_data and idle
// bus levels, and transaction length in bit times.

module tb_fsm_test;

  localparam int CD        = 5;
  localparam int BitClks   = 4 * CD;
  localparam int WaitLimit = 70 * BitClks;
`ifdef I2C_ACK_CHECK_EN
  localparam bit AckChk = 1'b1;
`else
  localparam bit AckChk = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        ready;
  logic        scl;
  wire         sda;
  logic [15:0] uv_data;

  logic        slave_low = 1'b0;
  bit          slave_en;
  logic [7:0]  slave_msb;
  logic [7:0]  slave_lsb;

  pullup (sda);
  assign sda = slave_low ? 1'b0 : 1'bz;

  always #5 clk = ~clk;

  fsm_test #(
    .CLK_DIV  (CD),
    .CMD_BYTE (8'h06)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .ready   (ready),
    .i2c_scl (scl),
    .i2c_sda (sda),
    .uv_data (uv_data)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- slave model / bus monitor ----------------
  logic [7:0] obs[$];       // bytes written by the master, in bus order
  bit         p_scl = 1'b1;
  bit         p_sda = 1'b1;
  bit         in_frame = 1'b0;
  int         bit_cnt = 0;
  int         byte_no = 0;
  logic [7:0] shreg = 8'h00;
  bit         rw = 1'b0;
  logic [7:0] rd_byte = 8'h00;

  always @(negedge clk) begin
    bit sc;
    bit sd;
    sc = scl;
    sd = (sda !== 1'b0);
    if (rst) begin
      in_frame  = 1'b0;
      slave_low = 1'b0;
      p_scl     = 1'b1;
      p_sda     = 1'b1;
    end else begin
      if (p_scl && sc && p_sda && !sd) begin
        in_frame = 1'b1;
        bit_cnt  = 0;
        byte_no  = 0;
        shreg    = 8'h00;
      end else if (p_scl && sc && !p_sda && sd) begin
        in_frame  = 1'b0;
        slave_low = 1'b0;
      end else if (in_frame && !p_scl && sc) begin
        if (bit_cnt < 8) begin
          shreg = {shreg[6:0], sd};
          bit_cnt++;
          if (bit_cnt == 8) begin
            if (byte_no == 0) begin
              rw      = shreg[0];
              rd_byte = (shreg == 8'h73) ? slave_msb : slave_lsb;
            end
            if (byte_no == 0 || !rw) obs.push_back(shreg);
          end
        end else begin
          bit_cnt = 0;
          byte_no++;
        end
      end else if (in_frame && p_scl && !sc) begin
        slave_low = 1'b0;
        if (slave_en) begin
          if (bit_cnt == 8 && (byte_no == 0 || !rw)) slave_low = 1'b1;
          else if (byte_no == 1 && rw && bit_cnt < 8) slave_low = !rd_byte[7-bit_cnt];
        end
      end
      p_scl = sc;
      p_sda = sd;
    end
  end

  // ---------------- behavioural model + compare ----------------
  bit          m_busy = 1'b0;
  int          m_cnt = 0;     // clocks since start was accepted
  int          m_nom = 0;     // nominal busy length in clocks
  logic [15:0] m_uv = 16'h0000;
  logic [15:0] m_exp_uv = 16'h0000;
  int          m_exp_n = 0;
  int          obs_rd = 0;
  int          txn_idx = 0;
  bit          post_rst = 1'b0;
  logic [7:0]  exp_bytes [4] = '{8'h70, 8'h06, 8'h73, 8'h71};

  always @(negedge clk) begin
    if (rst) begin
      chk("rst_ready", ready, 1);
      chk("rst_scl", scl, 1);
      chk("rst_uv", uv_data, 16'h0000);
      m_busy   = 1'b0;
      m_uv     = 16'h0000;
      obs_rd   = obs.size();
      post_rst = 1'b1;
    end else begin
      if (m_busy) begin
        m_cnt++;
        if (m_cnt < m_nom - 2) begin
          chk("busy_ready", ready, 0);
          chk("busy_uv_stable", uv_data, m_uv);
        end else if (ready) begin
          chk("done_window", (m_cnt <= m_nom + 2), 1);
          chk("done_uv", uv_data, m_exp_uv);
          chk("done_nbytes", obs.size() - obs_rd, m_exp_n);
          for (int i = 0; i < m_exp_n; i++)
            if (obs_rd + i < obs.size()) chk("done_byte", obs[obs_rd+i], exp_bytes[i]);
          if (txn_idx == 0) begin
            chk("t0_uv_literal", uv_data, 16'hA53C);
            chk("t0_len_literal", (m_cnt >= 1258 && m_cnt <= 1262), 1);
          end
          obs_rd = obs.size();
          txn_idx++;
          m_uv   = m_exp_uv;
          m_busy = 1'b0;
        end else if (m_cnt > m_nom + 2) begin
          chk("done_timeout", ready, 1);
          m_busy = 1'b0;
        end
      end else begin
        chk("idle_ready", ready, 1);
        chk("idle_uv", uv_data, m_uv);
        chk("idle_scl", scl, 1);
        chk("idle_sda", (sda !== 1'b0), 1);
        if (post_rst) begin
          chk("post_rst_ready_literal", ready, 1);
          chk("post_rst_uv_literal", uv_data, 16'h0000);
          post_rst = 1'b0;
        end
      end
      // start is stable here until the next rising edge samples it
      if (!m_busy && start) begin
        m_busy = 1'b1;
        m_cnt  = -1;
        if (AckChk && !slave_en) begin
          m_nom    = 12 * BitClks;
          m_exp_n  = 1;
          m_exp_uv = m_uv;
        end else begin
          m_nom    = 63 * BitClks;
          m_exp_n  = 4;
          m_exp_uv = slave_en ? {slave_msb, slave_lsb} : 16'hFFFF;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_idle(input bit noise);
    int n;
    n = 0;
    while (m_busy && n < WaitLimit) begin
      @(posedge clk); #1;
      if (noise && m_busy && m_cnt < m_nom - 10) start = 1'($urandom_range(0, 1));
      else start = 1'b0;
      n++;
    end
    if (m_busy) begin
      $display("FAIL wait_idle: still busy after %0d clocks, want idle", n);
      $fatal(1, "bench timeout");
    end
  endtask

  initial begin
    int r_at;
    int n;
    rst       = 1'b1;
    start     = 1'b0;
    slave_en  = 1'b1;
    slave_msb = 8'hA5;
    slave_lsb = 8'h3C;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Long idle with no request
    repeat (10000) @(posedge clk);

    // Single-clock request, known data
    pulse_start();
    wait_idle(1'b0);

    // start held until ready falls, then a second request later
    slave_msb = 8'h5A;
    slave_lsb = 8'hC3;
    @(posedge clk); #1 start = 1'b1;
    n = 0;
    do begin @(posedge clk); #1; n++; end while (ready && n < 10);
    start = 1'b0;
    wait_idle(1'b0);
    repeat (400) @(posedge clk);
    pulse_start();
    wait_idle(1'b0);

    // Random data with start toggling while busy
    for (int t = 0; t < 5; t++) begin
      slave_msb = 8'($urandom);
      slave_lsb = 8'($urandom);
      repeat ($urandom_range(1, 30)) @(posedge clk);
      pulse_start();
      wait_idle(1'b1);
    end

    // Reset in the middle of frame 2, then a normal transaction
    slave_msb = 8'($urandom);
    slave_lsb = 8'($urandom);
    r_at = $urandom_range(22 * BitClks, 41 * BitClks - 10);
    pulse_start();
    n = 0;
    while (m_busy && m_cnt < r_at && n < WaitLimit) begin @(posedge clk); n++; end
    #3 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (20) @(posedge clk);
    pulse_start();
    wait_idle(1'b0);

    // No slave on the bus: only the pull-up answers
    slave_en = 1'b0;
    repeat (10) @(posedge clk);
    pulse_start();
    wait_idle(1'b0);

    slave_en  = 1'b1;
    slave_msb = 8'h01;
    slave_lsb = 8'h80;
    pulse_start();
    wait_idle(1'b1);

    repeat (50) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
